// File: rtl/song_sequencer.sv
// Song ROM walker: fetches {note, duration} entries and strobes them into the note player.
// Optional macro SONG_SEQUENCER_LOOP_EN makes the current song repeat instead of advancing.
module song_sequencer #(
    parameter int NOTE_ADDR_W = 5,
    parameter int SONG_W      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          play,
    input  logic                          next_song,
    input  logic                          note_done,
    output logic [SONG_W+NOTE_ADDR_W-1:0] rom_addr,
    input  logic [11:0]                   rom_data,
    output logic [5:0]                    note_to_load,
    output logic [5:0]                    duration_to_load,
    output logic                          load_new_note,
    output logic                          song_done,
    output logic [SONG_W-1:0]             current_song
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_ROM,
        PLAYING,
        SONG_END
    } state_t;

    state_t                 state, state_n;
    logic [SONG_W-1:0]      song, song_n;
    logic [NOTE_ADDR_W-1:0] note_idx, idx_n;
    logic                   load_n;
    logic                   done_n;
    logic                   latch;

    assign current_song = song;

    always_comb begin
        state_n = state;
        song_n  = song;
        idx_n   = note_idx;
        load_n  = 1'b0;
        done_n  = 1'b0;
        latch   = 1'b0;
        case (state)
            IDLE: begin
                if (play) state_n = FETCH;
            end
            FETCH: begin
                if (play) state_n = WAIT_ROM;
            end
            WAIT_ROM: begin
                if (rom_data[5:0] == 6'd0) begin
                    state_n = SONG_END;
                end else begin
                    latch   = 1'b1;
                    load_n  = 1'b1;
                    state_n = PLAYING;
                end
            end
            PLAYING: begin
                if (note_done) begin
                    if (note_idx == '1) begin
                        state_n = SONG_END;
                    end else begin
                        idx_n   = note_idx + 1'b1;
                        state_n = FETCH;
                    end
                end
            end
            SONG_END: begin
                idx_n = '0;
`ifdef SONG_SEQUENCER_LOOP_EN
                state_n = FETCH;
`else
                song_n  = song + 1'b1;
                done_n  = 1'b1;
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
        // next_song overrides whatever the state decided this cycle
        if (next_song) begin
            song_n  = song + 1'b1;
            idx_n   = '0;
            state_n = IDLE;
            load_n  = 1'b0;
            done_n  = 1'b0;
            latch   = 1'b0;
        end
    end

    // rom_addr follows the next indices so FETCH always presents the updated address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            song             <= '0;
            note_idx         <= '0;
            rom_addr         <= '0;
            note_to_load     <= '0;
            duration_to_load <= '0;
            load_new_note    <= 1'b0;
            song_done        <= 1'b0;
        end else begin
            state         <= state_n;
            song          <= song_n;
            note_idx      <= idx_n;
            rom_addr      <= {song_n, idx_n};
            load_new_note <= load_n;
            song_done     <= done_n;
            if (latch) begin
                note_to_load     <= rom_data[11:6];
                duration_to_load <= rom_data[5:0];
            end
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a behavioural synchronous song ROM.
module tb_song_sequencer;

`ifdef SONG_SEQUENCER_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        play;
    logic        next_song;
    logic        note_done;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic        load_new_note;
    logic        song_done;
    logic [1:0]  current_song;

    logic [11:0] rom [128];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       play;
        logic       ns;
        logic       nd;
        logic       load;
        logic [5:0] note;
        logic [5:0] dur;
        logic       done;
        logic [1:0] song;
        logic [6:0] addr;
    } vec_t;

    vec_t vecs [16];

    song_sequencer #(.NOTE_ADDR_W(5), .SONG_W(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .next_song        (next_song),
        .note_done        (note_done),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .load_new_note    (load_new_note),
        .song_done        (song_done),
        .current_song     (current_song)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic p, input logic ns, input logic nd);
        play      = p;
        next_song = ns;
        note_done = nd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        play      = 1'b0;
        next_song = 1'b0;
        note_done = 1'b0;
        reset     = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 12'h000;
        rom[0]  = {6'd12, 6'd24};
        rom[1]  = {6'd0,  6'd5};
        rom[2]  = {6'd33, 6'd1};
        rom[32] = {6'd7,  6'd10};
        rom[33] = {6'd8,  6'd11};
        rom[64] = {6'd20, 6'd2};
        rom[65] = {6'd21, 6'd3};
        rom[66] = {6'd22, 6'd4};
        rom[67] = {6'd23, 6'd5};
        for (int i = 0; i < 32; i++) rom[96+i] = {6'(i + 1), 6'(i + 1)};

        //              play ns  nd   load  note   dur    done song  addr
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 2'd0, 7'h00};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 2'd0, 7'h00};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 6'd12, 6'd24, 1'b0, 2'd0, 7'h00};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd12, 6'd24, 1'b0, 2'd0, 7'h00};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd12, 6'd24, 1'b0, 2'd0, 7'h01};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd12, 6'd24, 1'b0, 2'd0, 7'h01};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 6'd0,  6'd5,  1'b0, 2'd0, 7'h01};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd5,  1'b0, 2'd0, 7'h01};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  6'd5,  1'b0, 2'd0, 7'h02};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd5,  1'b0, 2'd0, 7'h02};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd5,  1'b0, 2'd0, 7'h02};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  6'd5,  1'b0, 2'd0, 7'h02};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'd33, 6'd1,  1'b0, 2'd0, 7'h02};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd33, 6'd1,  1'b0, 2'd0, 7'h03};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd33, 6'd1,  1'b0, 2'd0, 7'h03};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd33, 6'd1,  1'b0, 2'd0, 7'h03};

        // reset held with random inputs
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            play      = 1'($urandom);
            next_song = 1'($urandom);
            note_done = 1'($urandom);
            @(posedge clk);
            #1;
            check("rst_load", load_new_note, 0);
            check("rst_done", song_done, 0);
            check("rst_addr", rom_addr, 0);
            check("rst_note", note_to_load, 0);
            check("rst_dur", duration_to_load, 0);
            check("rst_song", current_song, 0);
        end
        play = 1'b0; next_song = 1'b0; note_done = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            check("paused_load", load_new_note, 0);
        end

        // basic play / pause / rest / end-marker walk on song 0
        for (int i = 0; i < 16; i++) begin
            tick(vecs[i].play, vecs[i].ns, vecs[i].nd);
            check($sformatf("v%0d_load", i), load_new_note, vecs[i].load);
            check($sformatf("v%0d_note", i), note_to_load, vecs[i].note);
            check($sformatf("v%0d_dur", i), duration_to_load, vecs[i].dur);
            check($sformatf("v%0d_done", i), song_done, vecs[i].done);
            check($sformatf("v%0d_song", i), current_song, vecs[i].song);
            check($sformatf("v%0d_addr", i), rom_addr, vecs[i].addr);
        end
        tick(1'b1, 1'b0, 1'b0);
        check("s0_end_done", song_done, LOOP ? 0 : 1);
        check("s0_end_song", current_song, LOOP ? 0 : 1);
        check("s0_end_addr", rom_addr, LOOP ? 7'h00 : 7'h20);
        tick(1'b1, 1'b0, 1'b0);
        check("s0_done_pulse", song_done, 0);

        // song 1: end marker at entry 2
        do_reset();
        tick(1'b0, 1'b1, 1'b0);
        check("ns_song1", current_song, 1);
        check("ns_addr1", rom_addr, 7'h20);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("s1e0_load", load_new_note, 1);
        check("s1e0_note", note_to_load, 7);
        check("s1e0_dur", duration_to_load, 10);
        tick(1'b1, 1'b0, 1'b1);
        check("s1_addr21", rom_addr, 7'h21);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("s1e1_load", load_new_note, 1);
        check("s1e1_note", note_to_load, 8);
        check("s1e1_dur", duration_to_load, 11);
        tick(1'b1, 1'b0, 1'b1);
        check("s1_addr22", rom_addr, 7'h22);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("s1_marker_noload", load_new_note, 0);
        check("s1_marker_nodone", song_done, 0);
        tick(1'b1, 1'b0, 1'b0);
        check("s1_end_done", song_done, LOOP ? 0 : 1);
        check("s1_end_song", current_song, LOOP ? 1 : 2);
        check("s1_end_addr", rom_addr, LOOP ? 7'h20 : 7'h40);
        tick(1'b1, 1'b0, 1'b0);
        check("s1_done_pulse", song_done, 0);
        repeat (LOOP ? 1 : 2) tick(1'b1, 1'b0, 1'b0);
        check("autostart_load", load_new_note, 1);
        check("autostart_note", note_to_load, LOOP ? 7 : 20);

        // next_song and note_done together while playing
        tick(1'b1, 1'b1, 1'b1);
        check("prio_song", current_song, LOOP ? 2 : 3);
        check("prio_addr", rom_addr, LOOP ? 7'h40 : 7'h60);
        check("prio_load", load_new_note, 0);
        check("prio_done", song_done, 0);
        tick(1'b0, 1'b0, 1'b0);
        check("prio_idle_load", load_new_note, 0);

        // song 3: all 32 entries, index wrap ends the song
        do_reset();
        repeat (3) tick(1'b0, 1'b1, 1'b0);
        check("ns_song3", current_song, 3);
        check("ns_addr3", rom_addr, 7'h60);
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            tick(1'b1, 1'b0, 1'b0);
            check($sformatf("s3e%0d_load", i), load_new_note, 1);
            check($sformatf("s3e%0d_note", i), note_to_load, i + 1);
            check($sformatf("s3e%0d_addr", i), rom_addr, 96 + i);
            tick(1'b1, 1'b0, 1'b1);
        end
        check("wrap_addr_hold", rom_addr, 7'h7F);
        check("wrap_nodone_yet", song_done, 0);
        tick(1'b1, 1'b0, 1'b0);
        check("wrap_done", song_done, LOOP ? 0 : 1);
        check("wrap_song", current_song, LOOP ? 3 : 0);
        check("wrap_addr", rom_addr, LOOP ? 7'h60 : 7'h00);

        // next_song while a valid entry sits on rom_data
        repeat (LOOP ? 1 : 2) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check("nsw_load", load_new_note, 0);
        check("nsw_done", song_done, 0);
        check("nsw_song", current_song, LOOP ? 0 : 1);
        check("nsw_addr", rom_addr, LOOP ? 7'h00 : 7'h20);

        // asynchronous reset in the middle of a note
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        check("pre_rst_load", load_new_note, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_load", load_new_note, 0);
        check("async_note", note_to_load, 0);
        check("async_dur", duration_to_load, 0);
        check("async_addr", rom_addr, 0);
        check("async_song", current_song, 0);
        @(posedge clk);
        #1;
        check("async_hold_load", load_new_note, 0);
        reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Controller that sequences the note player.
- Walks a song ROM entry by entry and hands each note and duration to the note player with a one-cycle load strobe.
- Waits for the note player's done indication, then advances to the next entry.
- Handles play/pause, an end-of-song marker, address wrap-around and a user "next song" request. Sits between the top-level button and MCU logic and the note player.

Parameters:
- NOTE_ADDR_W, 5, width of the per-song note index (32 entries per song).
- SONG_W, 2, width of the song index (4 songs).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- play  input  1  level; 1 = run, 0 = pause.
- next_song  input  1  single-cycle pulse; abort the current song and advance to the next one.
- note_done  input  1  from the note player; current note finished (pulse).
- rom_addr  output  SONG_W+NOTE_ADDR_W  song ROM address {song, note_idx}, registered.
- rom_data  input  12  ROM output {note[11:6], duration[5:0]}; synchronous ROM, 1-cycle latency.
- note_to_load  output  6  registered note to the note player.
- duration_to_load  output  6  registered duration to the note player.
- load_new_note  output  1  one-cycle strobe; note and duration are valid in the same cycle.
- song_done  output  1  one-cycle pulse at natural end of song.
- current_song  output  SONG_W  song index being played.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; song=0; note_idx=0; rom_addr=0.
  - note_to_load=0; duration_to_load=0; load_new_note=0; song_done=0.
  - Reset mid-note aborts immediately; no strobe is issued.
- rom_addr is always {song, note_idx}, registered, and updates the cycle after either index changes.
- FSM, one transition per clk edge:
  - IDLE: play=1 -> FETCH; else hold.
  - FETCH: the ROM samples rom_addr at this edge -> WAIT_ROM. If play=0, hold in FETCH.
  - WAIT_ROM: rom_data is valid; capture it at this edge.
    - duration field == 0 is the end marker -> END.
    - Otherwise latch note_to_load and duration_to_load, set load_new_note=1 for exactly one cycle, -> PLAYING.
  - PLAYING: hold until note_done=1.
    - On note_done: if note_idx == 2^NOTE_ADDR_W-1 -> END.
    - Otherwise note_idx+1 -> FETCH.
    - play=0 does not change state; the note player freezes itself.
  - END: song_done=1 for one cycle; song+1 (wraps 3->0); note_idx=0 -> IDLE.
- Latency: play sampled high in IDLE -> load_new_note high on the 3rd cycle after that edge. note_done -> next load_new_note on the 3rd cycle after the note_done edge.
- next_song=1 in any state:
  - song+1 (wraps), note_idx=0, -> IDLE.
  - load_new_note and song_done are forced 0 that cycle.
  - next_song takes priority over a simultaneous note_done, an end marker or an END transition.
- A note field of 0 is a rest and is passed through unchanged; only duration==0 marks end of song.
- note_to_load and duration_to_load hold their last values until the next load.
- play low in IDLE or FETCH stalls without issuing a strobe. With play held high, the next song starts automatically after END.

Optional Feature:
- Macro: SONG_SEQUENCER_LOOP_EN.
- When defined:
  - END does not advance song and does not pulse song_done.
  - note_idx resets to 0 and the FSM goes directly to FETCH, so the current song loops forever.
  - next_song still advances songs.
- When undefined: behaviour is exactly as described under Behaviour.

Test Plan:
- Reset check: hold reset=0 with random inputs -> all outputs 0 and rom_addr=0. Release reset with play=0 for 10 cycles -> no load_new_note.
- Basic load: song 0 entry 0 = {note 12, dur 24}; raise play -> load_new_note high on cycle 3 only, with note_to_load=12 and duration_to_load=24. Pulse note_done -> rom_addr=1, then the next strobe 3 cycles after note_done.
- End marker: song 1 entry 2 has dur=0 -> song_done pulses once after the 2nd note_done, current_song=2, rom_addr=0x40, and the next song starts with play held high.
- Index wrap: song 3 has 32 non-zero entries -> song_done after the 32nd note_done, current_song wraps to 0.
- Priority: next_song and note_done asserted in the same cycle while PLAYING on song 2 -> current_song=3, note_idx=0, no load_new_note and no song_done that cycle.
- Loop feature: with SONG_SEQUENCER_LOOP_EN defined, an end marker at entry 4 -> rom_addr returns to {song, 0}, song_done stays 0 and current_song is unchanged.
